// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file write port between the pipeline writeback (wb0)
//   and the long-latency writeback (wb1). wb0 normally wins. wb1 takes forced
//   priority once it has been refused MAX_WAIT cycles in a row. The winning
//   write is registered onto RegWrite/WriteAddr/WriteData with latency 1.
//   Optional feature macro: SCOREBOARD_EN
//     When defined, a busy bit per register tracks outstanding wb1 writes.
//     When undefined, rs1Busy/rs2Busy are tied low and issue* is ignored.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb0Valid,
  output logic            wb0Ready,
  input  logic [4:0]      wb0Addr,
  input  logic [XLEN-1:0] wb0Data,
  input  logic            wb1Valid,
  output logic            wb1Ready,
  input  logic [4:0]      wb1Addr,
  input  logic [XLEN-1:0] wb1Data,
  input  logic            issueValid,
  input  logic [4:0]      issueAddr,
  input  logic [4:0]      rs1Addr,
  input  logic [4:0]      rs2Addr,
  output logic            rs1Busy,
  output logic            rs2Busy,
  output logic            RegWrite,
  output logic [4:0]      WriteAddr,
  output logic [XLEN-1:0] WriteData
);

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  logic            force_s;
  logic            grant0_s;
  logic            grant1_s;
  logic [2:0]      wait_cnt_d, wait_cnt_q;
  logic            reg_write_d, reg_write_q;
  logic [4:0]      write_addr_d, write_addr_q;
  logic [XLEN-1:0] write_data_d, write_data_q;

  // Pick one winner per cycle; nobody is granted while reset is asserted.
  always_comb begin
    force_s  = wb1Valid && (wait_cnt_q == MAX_WAIT_C);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (force_s) begin
      grant1_s = 1'b1;
    end else if (wb0Valid) begin
      grant0_s = 1'b1;
    end else if (wb1Valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign wb0Ready = grant0_s;
  assign wb1Ready = grant1_s;

  // Count consecutive wb1 refusals, saturating at the forcing threshold.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!wb1Valid || grant1_s) begin
      wait_cnt_d = 3'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Next register-file write: x0 writes are accepted but never enabled.
  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (grant1_s) begin
      reg_write_d  = (wb1Addr != 5'd0);
      write_addr_d = wb1Addr;
      write_data_d = wb1Data;
    end else if (grant0_s) begin
      reg_write_d  = (wb0Addr != 5'd0);
      write_addr_d = wb0Addr;
      write_data_d = wb0Data;
    end else begin
      reg_write_d  = 1'b0;
    end
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= 3'd0;
      reg_write_q  <= 1'b0;
      write_addr_q <= 5'd0;
      write_data_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteAddr = write_addr_q;
  assign WriteData = write_data_q;

`ifdef SCOREBOARD_EN
  logic [NREG-1:0] busy_d, busy_q;

  // Clear on wb1 transfer, then set on issue so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (grant1_s) begin
      busy_d[wb1Addr] = 1'b0;
    end else begin
      busy_d[wb1Addr] = busy_q[wb1Addr];
    end
    if (issueValid && (issueAddr != 5'd0)) begin
      busy_d[issueAddr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
  end

  // Busy bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1Busy = busy_q[rs1Addr];
  assign rs2Busy = busy_q[rs2Addr];
`else
  logic unused_s;
  assign unused_s = ^{issueValid, issueAddr, rs1Addr, rs2Addr};
  assign rs1Busy  = 1'b0;
  assign rs2Busy  = 1'b0;
`endif

endmodule
